seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode 7-segment display. Latches a
//  packed hex word and scans one digit per refresh slot, decoding each nibble to a
//  glyph. Supports per-digit enables, decimal points, leading-zero blanking and an
//  anode guard interval against ghosting. Sits between system registers and the pins.
// PARAMETERS
//  NUM_DIGITS     4      digits scanned (1..8)
//  REFRESH_DIV    50000  clk cycles per digit slot (>=2)
//  GUARD          1      cycles at start of each slot with all anodes off (0..REFRESH_DIV-1)
//  SEG_ACTIVE_LOW 1      1: seg/dp pins drive 0 = lit
//  AN_ACTIVE_LOW  1      1: an pins drive 0 = digit selected
// PORTS
//  clk         in   1             system clock, rising edge
//  reset       in   1             synchronous, active-high
//  value       in   4*NUM_DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 rightmost
//  dp_in       in   NUM_DIGITS    decimal point request per digit
//  digit_en    in   NUM_DIGITS    1 = digit may light; sampled live, not shadowed
//  load        in   1             capture value/dp_in into the shadow register
//  blank_lz    in   1             enable leading-zero suppression
//  seg         out  7             segments; seg[0]=a ... seg[6]=g
//  dp          out  1             decimal point segment
//  an          out  NUM_DIGITS    anode selects; an[i] drives digit i
//  frame_done  out  1             1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//  Reset (sync, high): shadow=0, div=0, idx=0; seg/dp/an all inactive (0x7F/1/all-1s when
//   active-low); frame_done=0. Reset has priority over load. Reset mid-scan: the next
//   edge returns to the reset state and the scan restarts at digit 0.
//  Shadow: on load=1, shadow_val<=value and shadow_dp<=dp_in. The new data is visible
//   on outputs 2 edges after the load edge (1 to capture, 1 through the output register).
//  Divider: div counts 0..REFRESH_DIV-1 and wraps. At div==REFRESH_DIV-1, idx advances
//   and wraps NUM_DIGITS-1 -> 0. frame_done=1 for exactly the cycle after wrapping to 0.
//  Output register: seg/dp/an are all registered, updated every cycle from current
//   (idx, div, shadow, digit_en, blank_lz). Latency is 1 cycle; no combinational path
//   from any input to any pin.
//  Lit condition for digit idx: div>=GUARD && digit_en[idx] && !lz[idx].
//   lz[i]=blank_lz && all shadow nibbles j>=i are 0; lz[0] is always 0.
//  If lit: an = one-hot(idx), seg = glyph(nibble), dp = shadow_dp[idx].
//   Else: an, seg and dp are all inactive.
//  Glyphs (a..g, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   A=77 b=7C C=39 d=5E E=79 F=71. Invert when SEG_ACTIVE_LOW=1.
//  Simultaneous load and idx advance: the slot's first cycle uses the old shadow; the new
//   shadow applies from the following cycle. GUARD>=1 hides this.
//  At most one an bit is active in any cycle; no an bit is active in guard cycles.
// STRUCTURE
//  seven_seg_pkg: glyph table localparams GLYPH_0..GLYPH_F, SEG_OFF, and a
//   function hex_to_glyph(logic [3:0]) returning the active-high 7-bit pattern.
//  Sub-module hex_glyph_decoder: combinational nibble->seg with polarity param,
//   one instance fed by the muxed nibble. Divider, idx, lz logic and output regs stay local.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, both polarities active-low)
//  1 reset 2 cycles -> seg=7F, dp=1, an=F, frame_done=0; hold with load=1 -> still 7F.
//  2 load 16'h12AF, digit_en=F, blank_lz=0 -> slot 0: 1 guard cycle an=F, then an=E,
//    seg=0E ('F'); slot 1 seg=08 ('A'), an=D; frame_done every 16 cycles.
//  3 load 16'h0050, blank_lz=1 -> digits 3,2 never lit; digit1 seg=12 ('5');
//    digit0 seg=40 ('0'); blank_lz=0 -> digit3 lit with seg=40.
//  4 load 16'h0000, blank_lz=1 -> only an[0] ever asserts, seg=40; dp_in=4'h1 -> dp=0 in slot 0.
//  5 digit_en=4'b0101 -> an[1] and an[3] never 0; check one-hot/zero-hot an each cycle.
//  6 load on the idx-advance edge; reset asserted mid-slot 2 -> outputs inactive next
//    edge, scan resumes at digit 0, first frame_done after 16 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared glyph table and nibble-to-glyph helper
// for the multiplexed 7-segment display driver.
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // All segments dark, active-high sense
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            4'hF: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_glyph_decoder.sv
// Combinational nibble -> segment pattern
// with selectable pin polarity.
module hex_glyph_decoder
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] glyph;

    assign glyph = hex_to_glyph(nibble);
    assign seg   = ACTIVE_LOW ? ~glyph : glyph;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit 7-segment scanner with
// shadowed data, leading-zero blanking and anode guard.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_IDLE =
        SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic DP_IDLE = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE =
        AN_ACTIVE_LOW ? '1 : '0;

    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [DIV_W-1:0]        div;
    logic [IDX_W-1:0]        idx;

    logic [NUM_DIGITS-1:0]   lz;
    logic                    upper_zero;
    logic                    guard_ok;
    logic                    lit;
    logic [3:0]              nibble;
    logic [6:0]              glyph_seg;
    logic [NUM_DIGITS-1:0]   an_sel;

    // Capture the displayed word; reset wins over load
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
        end
    end

    // Slot divider and digit index; pulse on frame wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            div        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (div == DIV_LAST) begin
                div <= '0;
                if (idx == IDX_LAST) begin
                    idx        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    generate
        if (GUARD == 0) begin : g_no_guard
            assign guard_ok = 1'b1;
        end else begin : g_guard
            assign guard_ok = (div >= DIV_W'(GUARD));
        end
    endgenerate

    // Leading-zero mask: a digit blanks when it and all above are 0
    always_comb begin
        lz         = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (shadow_val[4*i +: 4] == 4'h0);
            lz[i]      = blank_lz & upper_zero;
        end
    end

    assign nibble = shadow_val[4*idx +: 4];
    assign lit    = guard_ok & digit_en[idx] & ~lz[idx];
    assign an_sel = NUM_DIGITS'(1) << idx;

    hex_glyph_decoder #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec (
        .nibble (nibble),
        .seg    (glyph_seg)
    );

    // Registered pin drive; dark whenever the digit is not lit
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_IDLE;
            dp  <= DP_IDLE;
            an  <= AN_IDLE;
        end else if (lit) begin
            seg <= glyph_seg;
            dp  <= shadow_dp[idx] ? ~DP_IDLE : DP_IDLE;
            an  <= AN_ACTIVE_LOW ? ~an_sel : an_sel;
        end else begin
            seg <= SEG_IDLE;
            dp  <= DP_IDLE;
            an  <= AN_IDLE;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized and directed checks of seven_seg_scanner
// against a time-indexed behavioural display model.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 1;

    localparam logic [6:0] GT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic          clk = 1'b0;
    logic          reset;
    logic [4*N-1:0] value;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  digit_en;
    logic          load;
    logic          blank_lz;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          frame_done;

    int n_vec = 0;
    int n_err = 0;

    // model: cycles since reset plus the captured word
    int            m_cnt = 0;
    logic [4*N-1:0] m_val = '0;
    logic [N-1:0]  m_dp = '0;

    // observation monitors
    logic [N-1:0]  seen;
    logic [6:0]    seg_at [N];
    logic          dp_at [N];
    int            n_fd;

    seven_seg_scanner #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .GUARD          (G),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        seen = '0;
        n_fd = 0;
        for (int d = 0; d < N; d++) begin
            seg_at[d] = 7'h7F;
            dp_at[d]  = 1'b1;
        end
    endtask

    // One clock: predict, advance, compare, update model
    task automatic step();
        logic [6:0] es;
        logic       ed;
        logic [N-1:0] ea;
        logic       ef;
        logic       lit;
        logic [3:0] nib;
        logic [4*N-1:0] hi;
        int d;
        int ph;
        es = 7'h7F;
        ed = 1'b1;
        ea = '1;
        ef = 1'b0;
        if (!reset) begin
            d   = (m_cnt / R) % N;
            ph  = m_cnt % R;
            hi  = m_val >> (4 * d);
            nib = hi[3:0];
            lit = (ph >= G) && digit_en[d]
                  && !(blank_lz && d != 0 && hi == 0);
            if (lit) begin
                es    = ~GT[nib];
                ed    = ~m_dp[d];
                ea    = '1;
                ea[d] = 1'b0;
            end
            ef = (m_cnt % (N * R)) == (N * R - 1);
        end
        @(posedge clk);
        #1;
        chk("seg", seg, es);
        chk("dp", dp, ed);
        chk("an", an, ea);
        chk("frame_done", frame_done, ef);
        chk("an_onehot", ($countones(~an) <= 1), 1);
        if (reset) begin
            m_cnt = 0;
            m_val = '0;
            m_dp  = '0;
        end else begin
            m_cnt++;
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!an[k]) begin
                seen[k]   = 1'b1;
                seg_at[k] = seg;
                dp_at[k]  = dp;
            end
        end
        if (frame_done) n_fd++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [4*N-1:0] v,
                           input logic [N-1:0] p);
        value = v;
        dp_in = p;
        load  = 1'b1;
        step();
        load  = 1'b0;
        run(2);
    endtask

    initial begin
        int k;
        bit hit;
        logic [4*N-1:0] msk;
        reset    = 1'b1;
        value    = '0;
        dp_in    = '0;
        digit_en = '1;
        load     = 1'b0;
        blank_lz = 1'b0;
        clr_mon();

        // reset, then reset held with load asserted
        run(2);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        value = 16'hFFFF;
        dp_in = 4'hF;
        load  = 1'b1;
        step();
        chk("rst_ld_seg", seg, 7'h7F);
        load  = 1'b0;
        reset = 1'b0;
        run(3);

        // basic scan of 12AF
        do_load(16'h12AF, 4'h0);
        clr_mon();
        run(32);
        chk("s2_fd_cnt", n_fd, 2);
        chk("s2_d0", seg_at[0], 7'h0E);
        chk("s2_d1", seg_at[1], 7'h08);
        chk("s2_seen", seen, 4'hF);

        // leading-zero blanking of 0050
        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        clr_mon();
        run(16);
        chk("s3_seen", seen, 4'h3);
        chk("s3_d1", seg_at[1], 7'h12);
        chk("s3_d0", seg_at[0], 7'h40);
        blank_lz = 1'b0;
        step();
        clr_mon();
        run(16);
        chk("s3_nolz_seen", seen, 4'hF);
        chk("s3_d3", seg_at[3], 7'h40);

        // all-zero word keeps digit 0
        blank_lz = 1'b1;
        do_load(16'h0000, 4'h1);
        clr_mon();
        run(16);
        chk("s4_seen", seen, 4'h1);
        chk("s4_d0", seg_at[0], 7'h40);
        chk("s4_dp0", dp_at[0], 1'b0);

        // digit enables
        blank_lz = 1'b0;
        digit_en = 4'b0101;
        do_load(16'h8421, 4'h0);
        clr_mon();
        run(32);
        chk("s5_seen", seen, 4'b0101);
        digit_en = '1;

        // load on the slot-advance edge
        k = 0;
        while ((m_cnt % R) != R - 1 && k < 8) begin
            step();
            k++;
        end
        chk("s6_align", m_cnt % R, R - 1);
        value = 16'h3C5A;
        dp_in = 4'hA;
        load  = 1'b1;
        step();
        load  = 1'b0;
        run(8);

        // reset in the middle of slot 2
        k = 0;
        while (!(((m_cnt / R) % N) == 2 && (m_cnt % R) == 1) && k < 20) begin
            step();
            k++;
        end
        chk("s6_mid", (m_cnt / R) % N, 2);
        reset = 1'b1;
        step();
        chk("s6_rst_an", an, 4'hF);
        chk("s6_rst_seg", seg, 7'h7F);
        reset = 1'b0;
        k   = 0;
        hit = 1'b0;
        while (!hit && k < 40) begin
            step();
            k++;
            hit = frame_done;
        end
        chk("s6_fd_lat", k, 16);

        // randomized traffic
        repeat (800) begin
            load = ($urandom_range(0, 9) == 0);
            if (load) begin
                msk   = 16'hFFFF >> (4 * $urandom_range(0, 4));
                value = 16'($urandom) & msk;
                dp_in = 4'($urandom);
            end
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        load  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
